// File: rtl/slack_update.sv
// Slack update for the ADMM solver: clamps u+y into z and x+g into v row by
// row, and tracks the largest per-lane slack change as the dual residual.
module slack_update #(
    parameter int STATE_DIM  = 12,
    parameter int INPUT_DIM  = 4,
    parameter int HORIZON    = 30,
    parameter int LANE_W     = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int IW         = INPUT_DIM * LANE_W,
    parameter int SW         = STATE_DIM * LANE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           active_horizon,
    input  logic [IW-1:0]         u_min,
    input  logic [IW-1:0]         u_max,
    input  logic [SW-1:0]         x_min,
    input  logic [SW-1:0]         x_max,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [IW-1:0]         u_q,
    input  logic [IW-1:0]         y_q,
    input  logic [IW-1:0]         z_q,
    input  logic [SW-1:0]         x_q,
    input  logic [SW-1:0]         g_q,
    input  logic [SW-1:0]         v_q,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [IW-1:0]         z_data_in,
    output logic                  z_wren,
    output logic [SW-1:0]         v_data_in,
    output logic                  v_wren,
    output logic [LANE_W-1:0]     dual_res_u,
    output logic [LANE_W-1:0]     dual_res_x,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE, Z_PHASE, V_PHASE, FINISH, DONE_ST
    } state_t;

    state_t state, state_nx;

    logic [31:0]           heff, heff_in;
    logic [ADDR_WIDTH-1:0] k;
    logic [1:0]            cyc;
    logic [LANE_W-1:0]     acc_u, acc_x;
    logic [LANE_W-1:0]     max_u, max_x, du, dx;
    logic [IW-1:0]         z_new;
    logic [SW-1:0]         v_new;
    logic                  launch, z_last, v_last, row_end;

    // Sum in LANE_W+1 bits so the bound compare sees the true value, no wrap.
    function automatic logic [LANE_W-1:0] clamp(
        input logic [LANE_W-1:0] a, b, lo, hi
    );
        logic [LANE_W:0] s;
        s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
        if ($signed(s) > $signed({hi[LANE_W-1], hi}))
            clamp = hi;
        else if ($signed(s) < $signed({lo[LANE_W-1], lo}))
            clamp = lo;
        else
            clamp = s[LANE_W-1:0];
    endfunction

    function automatic logic [LANE_W-1:0] absdiff(
        input logic [LANE_W-1:0] n, o
    );
        logic [LANE_W:0] d, m;
        d = {n[LANE_W-1], n} - {o[LANE_W-1], o};
        m = d[LANE_W] ? (~d + 1'b1) : d;
        absdiff = m[LANE_W] ? '1 : m[LANE_W-1:0];
    endfunction

    assign heff_in = (active_horizon > 32'(HORIZON)) ?
                     32'(HORIZON) : active_horizon;
    assign launch  = (state == IDLE) && start && !busy;
    assign z_last  = (32'(k) + 32'd2 == heff);
    assign v_last  = (32'(k) + 32'd1 == heff);
    assign row_end = (cyc == 2'd3) &&
                     ((state == Z_PHASE) ? z_last : v_last);

    always_comb begin
        z_new = '0;
        v_new = '0;
        max_u = acc_u;
        max_x = acc_x;
        du    = '0;
        dx    = '0;
        for (int i = 0; i < INPUT_DIM; i++) begin
            z_new[i*LANE_W +: LANE_W] = clamp(
                u_q[i*LANE_W +: LANE_W], y_q[i*LANE_W +: LANE_W],
                u_min[i*LANE_W +: LANE_W], u_max[i*LANE_W +: LANE_W]);
            du = absdiff(z_new[i*LANE_W +: LANE_W], z_q[i*LANE_W +: LANE_W]);
            if (du > max_u) max_u = du;
        end
        for (int i = 0; i < STATE_DIM; i++) begin
            v_new[i*LANE_W +: LANE_W] = clamp(
                x_q[i*LANE_W +: LANE_W], g_q[i*LANE_W +: LANE_W],
                x_min[i*LANE_W +: LANE_W], x_max[i*LANE_W +: LANE_W]);
            dx = absdiff(v_new[i*LANE_W +: LANE_W], v_q[i*LANE_W +: LANE_W]);
            if (dx > max_x) max_x = dx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    if (heff_in >= 32'd2)      state_nx = Z_PHASE;
                    else if (heff_in == 32'd1) state_nx = V_PHASE;
                    else                       state_nx = FINISH;
                end
            end
            Z_PHASE: if (row_end) state_nx = V_PHASE;
            V_PHASE: if (row_end) state_nx = FINISH;
            FINISH:  state_nx = DONE_ST;
            DONE_ST: if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Row timing: c0 address out, c1 RAM latency, c2 data in, c3 write pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            heff       <= '0;
            k          <= '0;
            cyc        <= '0;
            acc_u      <= '0;
            acc_x      <= '0;
            rd_addr    <= '0;
            wr_addr    <= '0;
            z_data_in  <= '0;
            v_data_in  <= '0;
            z_wren     <= 1'b0;
            v_wren     <= 1'b0;
            dual_res_u <= '0;
            dual_res_x <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            z_wren <= 1'b0;
            v_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        heff    <= heff_in;
                        acc_u   <= '0;
                        acc_x   <= '0;
                        busy    <= 1'b1;
                        k       <= '0;
                        cyc     <= '0;
                        rd_addr <= '0;
                    end
                end
                Z_PHASE, V_PHASE: begin
                    cyc <= cyc + 2'd1;
                    if (cyc == 2'd2) begin
                        wr_addr <= k;
                        if (state == Z_PHASE) begin
                            z_data_in <= z_new;
                            z_wren    <= 1'b1;
                            acc_u     <= max_u;
                        end else begin
                            v_data_in <= v_new;
                            v_wren    <= 1'b1;
                            acc_x     <= max_x;
                        end
                    end
                    if (cyc == 2'd3) begin
                        k       <= row_end ? '0 : k + 1'b1;
                        rd_addr <= row_end ? '0 : k + 1'b1;
                    end
                end
                FINISH: begin
                    dual_res_u <= acc_u;
                    dual_res_x <= acc_x;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                end
                DONE_ST: if (!start) done <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/slack_update.md
SLACK_UPDATE -- requirements
Module: slack_update

Interface
REQ-001 SHALL have parameter STATE_DIM, default 12, lanes per state row (nx).
REQ-002 SHALL have parameter INPUT_DIM, default 4, lanes per input row (nu).
REQ-003 SHALL have parameter HORIZON, default 30, maximum horizon length N.
REQ-004 SHALL have parameter LANE_W, default 16, signed two's-complement lane width; IW=INPUT_DIM*LANE_W, SW=STATE_DIM*LANE_W; lane j occupies bits [j*LANE_W +: LANE_W].
REQ-005 SHALL have parameter ADDR_WIDTH, default 9, RAM address width; one address per horizon row k.
REQ-006 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port start, input, 1, level request to run one slack update.
REQ-009 SHALL have port active_horizon, input, 32, horizon H in use.
REQ-010 SHALL have ports u_min, u_max, input, IW, per-lane input bounds.
REQ-011 SHALL have ports x_min, x_max, input, SW, per-lane state bounds.
REQ-012 SHALL have port rd_addr, output, ADDR_WIDTH, read address driven to all six trajectory RAMs.
REQ-013 SHALL have ports u_q, y_q, z_q, input, IW, read data of u, y, old z RAMs.
REQ-014 SHALL have ports x_q, g_q, v_q, input, SW, read data of x, g, old v RAMs.
REQ-015 SHALL have port wr_addr, output, ADDR_WIDTH, write address shared by z and v RAMs.
REQ-016 SHALL have ports z_data_in (output, IW) and z_wren (output, 1), new z write.
REQ-017 SHALL have ports v_data_in (output, SW) and v_wren (output, 1), new v write.
REQ-018 SHALL have ports dual_res_u, dual_res_x, output, LANE_W, unsigned max |new-old| slack change.
REQ-019 SHALL have ports busy and done, output, 1, run-in-progress and completion flags.

Function
REQ-020 SHALL use states IDLE, Z_PHASE, V_PHASE, FINISH, DONE_ST.
REQ-021 IDLE: start=1 with busy=0 SHALL latch Heff=min(active_horizon,HORIZON), clear both residual accumulators, set busy, enter Z_PHASE.
REQ-022 Each row SHALL take exactly 4 cycles: c0 drive rd_addr=k; c1 wait (RAMs have 2-cycle read latency); c2 capture q inputs; c3 compute, drive wr_addr=k, data and wren=1 for exactly this one cycle.
REQ-023 Z_PHASE SHALL process rows k=0..Heff-2 per lane: s=u+y computed in LANE_W+1 bits; z=u_max if s>u_max, else u_min if s<u_min, else s.
REQ-024 V_PHASE SHALL process rows k=0..Heff-1 identically with x+g and x_min/x_max, writing v.
REQ-025 Clamp priority SHALL be upper bound first; a lane with min>max therefore yields max when s>max, else min.
REQ-026 Per lane, |z_new-z_old| (resp. v) SHALL be computed in LANE_W+1 bits, saturated to 2^LANE_W-1, and folded into a running max.
REQ-027 Heff<=1 SHALL skip Z_PHASE writes (zero rows); Heff=0 SHALL skip both phases; no wren pulse in skipped phases.
REQ-028 FINISH SHALL copy accumulators to dual_res_u/dual_res_x in one cycle, then enter DONE_ST.
REQ-029 DONE_ST SHALL hold done=1, busy=0 until start=0, then return to IDLE with done=0.
REQ-030 start asserted while busy SHALL be ignored; active_horizon and bounds SHALL be sampled continuously, Heff only at launch.
REQ-031 Total latency start-to-done SHALL be 1+4*((Heff-1 clamped >=0)+Heff)+2 cycles.

Reset
REQ-032 rst=1 at any time, including mid-phase, SHALL force IDLE; rd_addr, wr_addr, z_data_in, v_data_in, dual_res_u, dual_res_x, accumulators = 0; z_wren, v_wren, busy, done = 0; no partial write completes.

Verification
REQ-033 H=3, u=y=0x0010 all lanes, bounds ±0x0018, z_q=0 -> two z writes of 0x0018 at rows 0,1; dual_res_u=0x0018.
REQ-034 x lane0=0x7FFF, g lane0=0x7FFF, x_max=0x7FFF -> v lane0=0x7FFF (no wrap); x=g=0x8000, x_min=0x8000 -> v=0x8000.
REQ-035 z_q=0x8000, z_new=0x7FFF -> dual_res_u=0xFFFF (saturated).
REQ-036 active_horizon=40 -> Heff=30: 29 z_wren pulses, 30 v_wren pulses, done at cycle 1+4*59+2=239.
REQ-037 active_horizon=0 -> no wren pulses, done after 3 cycles, residuals 0; start held high through done -> no relaunch until start drops.
REQ-038 rst pulsed during V_PHASE row 5 c3 -> v_wren drops immediately, all outputs 0, next start runs a full clean pass.
